// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS HI/LO multiply-divide unit.
package mips_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } muldiv_state_e;

  function automatic logic op_is_mul(input muldiv_op_e op);
    return ~op[1];
  endfunction

  function automatic logic op_is_signed(input muldiv_op_e op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/mips_muldiv_if.sv
// Core-side port bundle of the multiply-divide unit (operation request, mthi/mtlo, HI/LO).
interface mips_muldiv_if #(
  parameter int WIDTH = 32
);
  logic                   start;
  mips_pkg::muldiv_op_e   op;
  logic [WIDTH-1:0]       a;
  logic [WIDTH-1:0]       b;
  logic                   hi_we;
  logic                   lo_we;
  logic [WIDTH-1:0]       wdata;
  logic                   busy;
  logic                   done;
  logic [WIDTH-1:0]       hi;
  logic [WIDTH-1:0]       lo;

  modport master (
    output start, op, a, b, hi_we, lo_we, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, hi_we, lo_we, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mips_divstep.sv
// One restoring-division step: shift the next dividend bit into the partial remainder and
// subtract the divisor if it fits.
module mips_divstep #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);
  logic [WIDTH+1:0] diff;
  logic             diff_unused;

  assign diff    = {1'b0, rem_in, bit_in} - {2'b00, divisor};
  assign q_bit   = ~diff[WIDTH+1];
  // A successful subtract leaves less than the divisor, so bit WIDTH is always clear.
  assign diff_unused = diff[WIDTH];
  assign rem_out = q_bit ? diff[WIDTH-1:0] : {rem_in[WIDTH-2:0], bit_in};
endmodule

// File: rtl/mips_muldiv.sv
// MIPS HI/LO multiply-divide unit: shift-add multiply (or single-cycle with FAST_MUL),
// restoring divide on operand magnitudes, sign fix-up in a final cycle.
//   state | meaning
//   IDLE  | waiting; mthi/mtlo accepted, start latches operands
//   MUL   | one shift-add iteration per cycle, WIDTH cycles
//   DIV   | one restoring quotient bit per cycle, WIDTH cycles
//   FIX   | sign correction, HI/LO written, done pulses next cycle
module mips_muldiv
  import mips_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter bit FAST_MUL = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  mips_muldiv_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  muldiv_state_e state, state_nxt;

  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   acc_hi, acc_lo, opnd;
  logic               op_mul, neg_lo, neg_hi, div_zero;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q;
  logic               busy_c;

  logic               in_mul, in_signed, sign_a, sign_b, accept, cnt_tc;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] fast_prod, prod_fix;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   div_rem, quo_fix, rem_fix, fix_hi, fix_lo;
  logic               div_q;

  assign in_mul    = op_is_mul(bus.op);
  assign in_signed = op_is_signed(bus.op);
  assign sign_a    = in_signed & bus.a[WIDTH-1];
  assign sign_b    = in_signed & bus.b[WIDTH-1];
  assign mag_a     = sign_a ? -bus.a : bus.a;
  assign mag_b     = sign_b ? -bus.b : bus.b;
  assign fast_prod = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
  assign mul_sum   = {1'b0, acc_hi} + {1'b0, opnd};
  assign accept    = (state == ST_IDLE) && bus.start;
  assign cnt_tc    = (cnt == CW'(1));

  mips_divstep #(.WIDTH(WIDTH)) u_divstep (
    .rem_in  (acc_hi),
    .bit_in  (acc_lo[WIDTH-1]),
    .divisor (opnd),
    .rem_out (div_rem),
    .q_bit   (div_q)
  );

  // Quotient sign is sign(a)^sign(b); remainder follows the dividend.
  always_comb begin
    prod_fix = neg_lo ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    quo_fix  = div_zero ? '1 : (neg_lo ? -acc_lo : acc_lo);
    rem_fix  = neg_hi ? -acc_hi : acc_hi;
    fix_hi   = op_mul ? prod_fix[2*WIDTH-1:WIDTH] : rem_fix;
    fix_lo   = op_mul ? prod_fix[WIDTH-1:0] : quo_fix;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          if (!in_mul)       state_nxt = ST_DIV;
          else if (FAST_MUL) state_nxt = ST_FIX;
          else               state_nxt = ST_MUL;
        end
      end
      ST_MUL:  if (cnt_tc) state_nxt = ST_FIX;
      ST_DIV:  if (cnt_tc) state_nxt = ST_FIX;
      ST_FIX:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_c = (state != ST_IDLE);
  end

  assign bus.busy = busy_c;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      opnd     <= '0;
      op_mul   <= 1'b0;
      neg_lo   <= 1'b0;
      neg_hi   <= 1'b0;
      div_zero <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= (state == ST_FIX);
      case (state)
        ST_IDLE: begin
          if (accept) begin
            cnt      <= CW'(WIDTH);
            op_mul   <= in_mul;
            neg_lo   <= sign_a ^ sign_b;
            neg_hi   <= sign_a;
            div_zero <= ~in_mul & (bus.b == '0);
            opnd     <= in_mul ? mag_a : mag_b;
            if (FAST_MUL && in_mul) begin
              {acc_hi, acc_lo} <= fast_prod;
            end else begin
              acc_hi <= '0;
              acc_lo <= in_mul ? mag_b : mag_a;
            end
          end else begin
            if (bus.hi_we) hi_q <= bus.wdata;
            if (bus.lo_we) lo_q <= bus.wdata;
          end
        end
        ST_MUL: begin
          cnt <= cnt - CW'(1);
          if (acc_lo[0]) {acc_hi, acc_lo} <= {mul_sum, acc_lo[WIDTH-1:1]};
          else           {acc_hi, acc_lo} <= {1'b0, acc_hi, acc_lo[WIDTH-1:1]};
        end
        ST_DIV: begin
          cnt    <= cnt - CW'(1);
          acc_hi <= div_rem;
          acc_lo <= {acc_lo[WIDTH-2:0], div_q};
        end
        ST_FIX: begin
          hi_q <= fix_hi;
          lo_q <= fix_lo;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mips_muldiv.sv
// Directed bench for mips_muldiv: iterative and FAST_MUL instances side by side.
module tb_mips_muldiv;
  import mips_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mips_muldiv_if #(.WIDTH(W)) bus ();
  mips_muldiv_if #(.WIDTH(W)) bus_f ();

  mips_muldiv #(.WIDTH(W), .FAST_MUL(1'b0)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  mips_muldiv #(.WIDTH(W), .FAST_MUL(1'b1)) u_dut_fast (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_f)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit fast, input bit st, input muldiv_op_e op,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit hwe, input bit lwe, input logic [W-1:0] wd);
    if (fast) begin
      bus_f.start = st; bus_f.op = op; bus_f.a = a; bus_f.b = b;
      bus_f.hi_we = hwe; bus_f.lo_we = lwe; bus_f.wdata = wd;
    end else begin
      bus.start = st; bus.op = op; bus.a = a; bus.b = b;
      bus.hi_we = hwe; bus.lo_we = lwe; bus.wdata = wd;
    end
  endtask

  task automatic drive_idle(input bit fast);
    drive(fast, 1'b0, OP_MULT, '0, '0, 1'b0, 1'b0, '0);
  endtask

  // inject_k = 0 adds mthi/mtlo to the start cycle; inject_k > 0 fires a second
  // start plus mthi/mtlo in cycle k after E0.
  task automatic run_op(input bit fast, input muldiv_op_e op,
                        input logic [W-1:0] a, input logic [W-1:0] b, input int inject_k,
                        output logic [W-1:0] hi_r, output logic [W-1:0] lo_r,
                        output int busy_cyc, output int done_at, output int done_cnt,
                        output bit hold_ok);
    logic [W-1:0] hi0, lo0, hi_v, lo_v;
    logic bv, dv;
    hi0 = fast ? bus_f.hi : bus.hi;
    lo0 = fast ? bus_f.lo : bus.lo;
    drive(fast, 1'b1, op, a, b, inject_k == 0, inject_k == 0, 32'h5555_AAAA);
    @(posedge clk); #1;
    drive_idle(fast);
    busy_cyc = 0; done_at = -1; done_cnt = 0; hold_ok = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      if (k == inject_k)
        drive(fast, 1'b1, OP_MULTU, 32'hFFFF, 32'hFFFF, 1'b1, 1'b1, 32'hDEAD_BEEF);
      bv   = fast ? bus_f.busy : bus.busy;
      dv   = fast ? bus_f.done : bus.done;
      hi_v = fast ? bus_f.hi : bus.hi;
      lo_v = fast ? bus_f.lo : bus.lo;
      if (bv) busy_cyc++;
      if (dv) begin
        done_cnt++;
        if (done_at < 0) done_at = k - 1;
      end
      if (done_at < 0 && (hi_v !== hi0 || lo_v !== lo0)) hold_ok = 1'b0;
      @(posedge clk); #1;
      drive_idle(fast);
    end
    hi_r = fast ? bus_f.hi : bus.hi;
    lo_r = fast ? bus_f.lo : bus.lo;
  endtask

  task automatic check_op(input string tag, input bit fast, input muldiv_op_e op,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo,
                          input int exp_lat, input int inject_k);
    logic [W-1:0] hi_r, lo_r;
    int busy_cyc, done_at, done_cnt;
    bit hold_ok;
    run_op(fast, op, a, b, inject_k, hi_r, lo_r, busy_cyc, done_at, done_cnt, hold_ok);
    chk({tag, ".hi"}, 64'(hi_r), 64'(exp_hi));
    chk({tag, ".lo"}, 64'(lo_r), 64'(exp_lo));
    chk({tag, ".busy_cycles"}, 64'(busy_cyc), 64'(exp_lat));
    chk({tag, ".done_edge"}, 64'(done_at), 64'(exp_lat));
    chk({tag, ".done_pulses"}, 64'(done_cnt), 64'd1);
    chk({tag, ".hilo_held"}, 64'(hold_ok), 64'd1);
  endtask

  initial begin
    int cnt_done, cnt_busy;
    drive_idle(1'b0);
    drive_idle(1'b1);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst.busy", 64'(bus.busy), 64'd0);
    chk("rst.done", 64'(bus.done), 64'd0);
    chk("rst.hi", 64'(bus.hi), 64'd0);
    chk("rst.lo", 64'(bus.lo), 64'd0);
    chk("rst.fast_hilo", {bus_f.hi, bus_f.lo}, 64'd0);

    check_op("multu_max", 1'b0, OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33, -1);
    check_op("multu_max_fast", 1'b1, OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1, -1);
    check_op("mult_neg", 1'b0, OP_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 33, -1);
    check_op("mult_neg_fast", 1'b1, OP_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1, -1);
    check_op("mult_minsq", 1'b0, OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 33, -1);
    check_op("mult_m1sq", 1'b0, OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, 33, -1);
    check_op("div_neg", 1'b0, OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, -1);
    check_op("div_negdvsr", 1'b0, OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFD, 33, -1);
    check_op("div_ovf", 1'b0, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 33, -1);
    check_op("divu_zero", 1'b0, OP_DIVU, 32'h0000_1234, 32'h0, 32'h0000_1234, 32'hFFFF_FFFF, 33, -1);
    check_op("div_zero_neg", 1'b0, OP_DIV, 32'hFFFF_FFF9, 32'h0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 33, -1);
    check_op("divu_big", 1'b0, OP_DIVU, 32'hFFFF_FFFF, 32'd10, 32'd5, 32'h1999_9999, 33, -1);
    check_op("divu_fast", 1'b1, OP_DIVU, 32'hFFFF_FFFF, 32'd10, 32'd5, 32'h1999_9999, 33, -1);

    // mthi alone, then a divide with a second start and mthi/mtlo fired mid-flight
    drive(1'b0, 1'b0, OP_MULT, '0, '0, 1'b1, 1'b0, 32'hA5A5_A5A5);
    @(posedge clk); #1;
    drive_idle(1'b0);
    chk("mthi.hi", 64'(bus.hi), 64'h0000_0000_A5A5_A5A5);
    chk("mthi.lo_kept", 64'(bus.lo), 64'h0000_0000_1999_9999);
    check_op("divu_10_3", 1'b0, OP_DIVU, 32'd10, 32'd3, 32'd1, 32'd3, 33, 5);

    drive(1'b0, 1'b0, OP_MULT, '0, '0, 1'b1, 1'b1, 32'h0F0F_0F0F);
    @(posedge clk); #1;
    drive_idle(1'b0);
    chk("mthilo.hi", 64'(bus.hi), 64'h0000_0000_0F0F_0F0F);
    chk("mthilo.lo", 64'(bus.lo), 64'h0000_0000_0F0F_0F0F);
    check_op("start_wins", 1'b0, OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 33, 0);

    // reset in cycle 10 of a multiply, with start and mthi asserted alongside it
    drive(1'b0, 1'b1, OP_MULT, 32'd7, 32'd9, 1'b0, 1'b0, '0);
    @(posedge clk); #1;
    drive_idle(1'b0);
    repeat (9) begin @(posedge clk); #1; end
    chk("rstmid.busy_before", 64'(bus.busy), 64'd1);
    reset = 1'b1;
    drive(1'b0, 1'b1, OP_MULTU, 32'd5, 32'd5, 1'b1, 1'b1, 32'hFFFF_0000);
    @(posedge clk); #1;
    reset = 1'b0;
    drive_idle(1'b0);
    chk("rstmid.busy", 64'(bus.busy), 64'd0);
    chk("rstmid.hi", 64'(bus.hi), 64'd0);
    chk("rstmid.lo", 64'(bus.lo), 64'd0);
    cnt_done = 0;
    cnt_busy = 0;
    for (int k = 0; k < 40; k++) begin
      if (bus.done) cnt_done++;
      if (bus.busy) cnt_busy++;
      @(posedge clk); #1;
    end
    chk("rstmid.no_done", 64'(cnt_done), 64'd0);
    chk("rstmid.no_busy", 64'(cnt_busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mips_muldiv.md
MIPS_MULDIV -- requirements
Module: mips_muldiv

Interface
REQ-001 Parameter: WIDTH, default 32, operand and HI/LO width (legal 8..64, even).
REQ-002 Parameter: FAST_MUL, default 0; 1 = single-cycle multiply, 0 = iterative multiply.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request to begin an operation; sampled at a rising edge.
REQ-006 op  input  2  00 mult, 01 multu, 10 div, 11 divu.
REQ-007 a  input  WIDTH  multiplicand or dividend (rs).
REQ-008 b  input  WIDTH  multiplier or divisor (rt).
REQ-009 hi_we  input  1  mthi write strobe.
REQ-010 lo_we  input  1  mtlo write strobe.
REQ-011 wdata  input  WIDTH  data for mthi/mtlo.
REQ-012 busy  output  1  operation in progress; the core stalls mfhi/mflo/mult/div while high.
REQ-013 done  output  1  one-cycle pulse; new HI/LO are valid.
REQ-014 hi  output  WIDTH  HI register.
REQ-015 lo  output  WIDTH  LO register.

Function
REQ-016 FSM states: IDLE, MUL, DIV, FIX.
REQ-017 IDLE + start: latch op, a and b at that edge (E0).
REQ-018 From IDLE + start, the FSM goes to MUL (op 0x) or DIV (op 1x).
REQ-019 Signed ops: the FSM latches operand magnitudes plus the result signs.
REQ-020 MUL and DIV each run exactly WIDTH iteration cycles, then pass to FIX for one cycle.
REQ-021 FIX applies the sign correction, writes HI/LO, and returns to IDLE.
REQ-022 Iterative latency: busy is high for WIDTH+1 cycles after E0, HI/LO update at edge E0+WIDTH+1, and done is high in the cycle following that edge.
REQ-023 FAST_MUL=1 latency for mult/multu: HI/LO update at E0+1, busy is high for one cycle, and done is high in the cycle after E0+1.
REQ-024 Divide latency is always the iterative latency, independent of FAST_MUL.
REQ-025 Multiply result: the full 2*WIDTH-bit product, with {hi,lo} = a*b (signed or unsigned per op).
REQ-026 Divide uses restoring division: one quotient bit per cycle, MSB first.
REQ-027 Signed divide: lo = quotient truncated toward zero; hi = remainder carrying the dividend's sign.
REQ-028 Divide by zero (div or divu): lo = all ones, hi = a, with normal latency.
REQ-029 Signed overflow (most-negative / -1): lo = most-negative value, hi = 0.
REQ-030 HI/LO hold their previous values until the completion edge; no partial results are visible.
REQ-031 start while busy is ignored; the operation in flight is unaffected.
REQ-032 hi_we/lo_we while busy are ignored.
REQ-033 In IDLE, hi_we loads wdata into HI and lo_we loads wdata into LO; both may fire in the same cycle.
REQ-034 start together with hi_we/lo_we in IDLE: start wins and the writes are discarded.
REQ-035 done is never asserted without a preceding accepted start; it is combinationally independent of inputs.
REQ-036 A counter of ceil(log2(WIDTH+1)) bits tracks the iterations; no wrap is possible within one operation.

Reset
REQ-037 reset returns the FSM to IDLE and sets busy=0, done=0, hi=0, lo=0, with the iteration counter and operand latches cleared.
REQ-038 reset mid-operation aborts it: no done pulse, and HI/LO are 0 at the next cycle.
REQ-039 reset overrides start, hi_we and lo_we in the same cycle.

Structure
REQ-040 Shared package mips_pkg holds the op encodings (MULT, MULTU, DIV, DIVU) and the muldiv state enum.
REQ-041 Sub-module mips_divstep is the combinational restoring-division step (partial remainder, divisor -> next remainder, quotient bit).
REQ-042 Multiply shift-add and sign fix-up are implemented inline; no other sub-modules.

Verification (WIDTH=32 unless stated)
REQ-043 multu a=0xFFFFFFFF b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; busy for 33 cycles; done pulse once. Repeat with FAST_MUL=1 -> same result with busy for 1 cycle.
REQ-044 mult a=0xFFFFFFFD (-3) b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
REQ-045 div a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; div a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-046 divu a=0x00001234 b=0 -> lo=0xFFFFFFFF, hi=0x00001234, done at E0+33.
REQ-047 mthi 0xA5A5A5A5 in IDLE -> hi=0xA5A5A5A5 next cycle; then start divu 10/3, with hi_we and a second start at cycle 5 ignored -> lo=3, hi=1.
REQ-048 start mult, reset at cycle 10 -> busy=0, hi=lo=0, and no done within the next 40 cycles.
